// File: rtl/atm_account_server.sv
// rtl/atm_account_server.sv - bank-side account table answering ATM requests over valid/ready
module atm_account_server #(
    parameter int          NUM_ACCOUNTS = 4,
    parameter logic [16:0] ACCT_BASE    = 17'd1000,
    parameter logic [18:0] INIT_BALANCE = 19'd5000,
    parameter logic [16:0] INIT_PIN     = 17'd1234,
    parameter int          MAX_TRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [16:0] req_account,
    input  logic [16:0] req_pin,
    input  logic [16:0] req_new_pin,
    input  logic [16:0] req_dest_account,
    input  logic [18:0] req_amount,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_ok,
    output logic [2:0]  rsp_status,
    output logic [18:0] rsp_balance
);

    typedef enum logic [1:0] {IDLE, CHECK, EXEC, RESP} state_t;

    state_t state, state_next;

    logic [2:0]  op_q;
    logic [16:0] acct_q;
    logic [16:0] pin_q;
    logic [16:0] new_pin_q;
    logic [16:0] dest_q;
    logic [18:0] amount_q;

    // Tables are sized for the largest allowed depth so a 4-bit index always fits.
    logic [18:0] bal_tbl   [16];
    logic [16:0] pin_tbl   [16];
    logic [7:0]  fails_tbl [16];
    logic [15:0] locked_tbl;

    logic [16:0] src_off, dst_off;
    logic [3:0]  src_idx, dst_idx;
    logic        src_in, dst_in;
    logic [18:0] src_bal, dst_bal;
    logic [19:0] src_sum, dst_sum;
    logic [7:0]  fails_inc;
    logic [2:0]  status_comb;
    logic [2:0]  chk_status;

    always_comb begin
        src_off   = acct_q - ACCT_BASE;
        dst_off   = dest_q - ACCT_BASE;
        src_in    = (acct_q >= ACCT_BASE) && (src_off < 17'(NUM_ACCOUNTS));
        dst_in    = (dest_q >= ACCT_BASE) && (dst_off < 17'(NUM_ACCOUNTS));
        src_idx   = src_off[3:0];
        dst_idx   = dst_off[3:0];
        src_bal   = bal_tbl[src_idx];
        dst_bal   = bal_tbl[dst_idx];
        src_sum   = {1'b0, src_bal} + {1'b0, amount_q};
        dst_sum   = {1'b0, dst_bal} + {1'b0, amount_q};
        fails_inc = fails_tbl[src_idx] + 8'd1;
    end

    // Ordered rule chain: the first failing rule decides the status.
    always_comb begin
        status_comb = 3'd0;
        if (op_q > 3'd4)
            status_comb = 3'd6;
        else if (!src_in)
            status_comb = 3'd1;
        else if (locked_tbl[src_idx])
            status_comb = 3'd3;
        else if (pin_q != pin_tbl[src_idx])
            status_comb = 3'd2;
        else if (op_q == 3'd1 && amount_q > src_bal)
            status_comb = 3'd4;
        else if (op_q == 3'd2 && src_sum[19])
            status_comb = 3'd5;
        else if (op_q == 3'd3 && (!dst_in || dest_q == acct_q))
            status_comb = 3'd7;
        else if (op_q == 3'd3 && amount_q > src_bal)
            status_comb = 3'd4;
        else if (op_q == 3'd3 && dst_sum[19])
            status_comb = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = CHECK;
            end
            CHECK: state_next = EXEC;
            EXEC:  state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            acct_q      <= '0;
            pin_q       <= '0;
            new_pin_q   <= '0;
            dest_q      <= '0;
            amount_q    <= '0;
            chk_status  <= '0;
            rsp_ok      <= 1'b0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            locked_tbl  <= '0;
            for (int i = 0; i < 16; i++) begin
                bal_tbl[i]   <= INIT_BALANCE;
                pin_tbl[i]   <= INIT_PIN;
                fails_tbl[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        acct_q    <= req_account;
                        pin_q     <= req_pin;
                        new_pin_q <= req_new_pin;
                        dest_q    <= req_dest_account;
                        amount_q  <= req_amount;
                    end
                end
                CHECK: chk_status <= status_comb;
                EXEC: begin
                    rsp_status <= chk_status;
                    rsp_ok     <= (chk_status == 3'd0);
                    case (chk_status)
                        3'd0: begin
                            fails_tbl[src_idx] <= '0;
                            rsp_balance        <= src_bal;
                            case (op_q)
                                3'd1: begin
                                    bal_tbl[src_idx] <= src_bal - amount_q;
                                    rsp_balance      <= src_bal - amount_q;
                                end
                                3'd2: begin
                                    bal_tbl[src_idx] <= src_sum[18:0];
                                    rsp_balance      <= src_sum[18:0];
                                end
                                3'd3: begin
                                    bal_tbl[src_idx] <= src_bal - amount_q;
                                    bal_tbl[dst_idx] <= dst_sum[18:0];
                                    rsp_balance      <= src_bal - amount_q;
                                end
                                3'd4: pin_tbl[src_idx] <= new_pin_q;
                                default: ;
                            endcase
                        end
                        3'd2: begin
                            rsp_balance        <= src_bal;
                            fails_tbl[src_idx] <= fails_inc;
                            // The attempt that hits the limit already reports the lock.
                            if (fails_inc >= 8'(MAX_TRIES)) begin
                                locked_tbl[src_idx] <= 1'b1;
                                rsp_status          <= 3'd3;
                            end
                        end
                        default: rsp_balance <= src_in ? src_bal : '0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_server.sv
// tb/tb_atm_account_server.sv - directed bench with account-table model and response scoreboard
module tb_atm_account_server;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [16:0] req_account = '0;
    logic [16:0] req_pin = '0;
    logic [16:0] req_new_pin = '0;
    logic [16:0] req_dest_account = '0;
    logic [18:0] req_amount = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_ok;
    logic [2:0]  rsp_status;
    logic [18:0] rsp_balance;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int status;
        int balance;
    } exp_t;

    exp_t exp_q[$];
    int   m_bal[4];
    int   m_pin[4];
    int   m_fails[4];
    bit   m_lock[4];

    logic [2:0]  got_status;
    logic        got_ok;
    logic [18:0] got_bal;

    always #5 clk = ~clk;

    atm_account_server dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_account(req_account),
        .req_pin(req_pin),
        .req_new_pin(req_new_pin),
        .req_dest_account(req_dest_account),
        .req_amount(req_amount),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_ok(rsp_ok),
        .rsp_status(rsp_status),
        .rsp_balance(rsp_balance)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i]   = 5000;
            m_pin[i]   = 1234;
            m_fails[i] = 0;
            m_lock[i]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_apply(input int op, input int acct, input int pin, input int npin,
                               input int dest, input int amt, output exp_t e);
        int  s;
        int  d;
        bit  s_ok;
        bit  d_ok;
        s    = acct - 1000;
        d    = dest - 1000;
        s_ok = (s >= 0) && (s < 4);
        d_ok = (d >= 0) && (d < 4);
        e.status = 0;
        if (op > 4) e.status = 6;
        else if (!s_ok) e.status = 1;
        else if (m_lock[s]) e.status = 3;
        else if (pin != m_pin[s]) e.status = 2;
        else if (op == 1 && amt > m_bal[s]) e.status = 4;
        else if (op == 2 && m_bal[s] + amt > 524287) e.status = 5;
        else if (op == 3 && (!d_ok || d == s)) e.status = 7;
        else if (op == 3 && amt > m_bal[s]) e.status = 4;
        else if (op == 3 && m_bal[d] + amt > 524287) e.status = 5;
        if (e.status == 0) begin
            m_fails[s] = 0;
            case (op)
                1: m_bal[s] = m_bal[s] - amt;
                2: m_bal[s] = m_bal[s] + amt;
                3: begin
                    m_bal[s] = m_bal[s] - amt;
                    m_bal[d] = m_bal[d] + amt;
                end
                4: m_pin[s] = npin;
                default: ;
            endcase
        end else if (e.status == 2) begin
            m_fails[s]++;
            if (m_fails[s] >= 3) begin
                m_lock[s] = 1;
                e.status  = 3;
            end
        end
        e.balance = s_ok ? m_bal[s] : 0;
    endtask

    // Scoreboard: every cycle a response is presented it must match the head expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                chk("sb_status", 32'(rsp_status), 32'(exp_q[0].status));
                chk("sb_ok", 32'(rsp_ok), 32'(exp_q[0].status == 0));
                chk("sb_balance", 32'(rsp_balance), 32'(exp_q[0].balance));
                if (rsp_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_ok"}, 32'(rsp_ok), 32'd0);
        chk({tag, ".rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, ".rsp_balance"}, 32'(rsp_balance), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
    endtask

    task automatic do_req(input int op, input int acct, input int pin, input int npin,
                          input int dest, input int amt, input int hold, input bit chk_lat,
                          input bit intrude);
        exp_t e;
        int   n;
        int   lat;
        model_apply(op, acct, pin, npin, dest, amt, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid        = 1'b1;
        req_op           = 3'(op);
        req_account      = 17'(acct);
        req_pin          = 17'(pin);
        req_new_pin      = 17'(npin);
        req_dest_account = 17'(dest);
        req_amount       = 19'(amt);
        rsp_ready        = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        if (chk_lat)
            chk("latency_edges_incl_accept", 32'(lat), 32'd3);
        for (int i = 0; i < hold; i++) begin
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            if (intrude && i == 0) begin
                req_valid   = 1'b1;
                req_op      = 3'd1;
                req_account = 17'd1001;
                req_pin     = 17'd1234;
                req_amount  = 19'd100;
            end
            if (i == hold - 1) begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        got_status = rsp_status;
        got_ok     = rsp_ok;
        got_bal    = rsp_balance;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic req(input int op, input int acct, input int pin, input int npin,
                       input int dest, input int amt);
        do_req(op, acct, pin, npin, dest, amt, 0, 1'b0, 1'b0);
    endtask

    task automatic expect_lit(input string name, input int st, input int bal);
        chk({name, ".status"}, 32'(got_status), 32'(st));
        chk({name, ".ok"}, 32'(got_ok), 32'(st == 0));
        chk({name, ".balance"}, 32'(got_bal), 32'(bal));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();

        do_req(0, 1000, 1234, 0, 0, 0, 0, 1'b1, 1'b0);
        expect_lit("bal_1000", 0, 5000);

        req(1, 1001, 1234, 0, 0, 2000);
        expect_lit("wd_2000", 0, 3000);
        req(1, 1001, 1234, 0, 0, 3001);
        expect_lit("wd_insuff", 4, 3000);
        req(1, 1001, 1234, 0, 0, 0);
        expect_lit("wd_zero", 0, 3000);

        req(3, 1000, 1234, 0, 1002, 1500);
        expect_lit("xfer_ok", 0, 3500);
        req(0, 1002, 1234, 0, 0, 0);
        expect_lit("bal_1002", 0, 6500);
        req(3, 1000, 1234, 0, 1000, 10);
        expect_lit("xfer_same", 7, 3500);
        req(3, 1000, 1234, 0, 1004, 10);
        expect_lit("xfer_range", 7, 3500);
        req(1, 999, 1234, 0, 0, 1);
        expect_lit("bad_acct", 1, 0);

        req(0, 1003, 1111, 0, 0, 0);
        expect_lit("pin_bad1", 2, 5000);
        req(0, 1003, 1111, 0, 0, 0);
        expect_lit("pin_bad2", 2, 5000);
        req(0, 1003, 1111, 0, 0, 0);
        expect_lit("pin_bad3", 3, 5000);
        req(0, 1003, 1234, 0, 0, 0);
        expect_lit("locked", 3, 5000);
        do_reset();
        req(0, 1003, 1234, 0, 0, 0);
        expect_lit("unlocked", 0, 5000);

        req(2, 1000, 1234, 0, 0, 19'h7FFFF);
        expect_lit("dep_ovf", 5, 5000);
        req(4, 1000, 1234, 4321, 0, 0);
        expect_lit("pin_chg", 0, 5000);
        req(0, 1000, 1234, 0, 0, 0);
        expect_lit("old_pin", 2, 5000);
        req(0, 1000, 4321, 0, 0, 0);
        expect_lit("new_pin", 0, 5000);

        req(2, 1002, 1234, 0, 0, 519287);
        expect_lit("dep_max", 0, 524287);
        req(3, 1001, 1234, 0, 1002, 1);
        expect_lit("xfer_dst_ovf", 5, 5000);

        do_req(0, 1001, 1234, 0, 0, 0, 5, 1'b0, 1'b1);
        expect_lit("hold", 0, 5000);
        @(negedge clk);
        chk("post_hold_idle", 32'(req_ready), 32'd1);
        req(0, 1001, 1234, 0, 0, 0);
        expect_lit("intruder_ignored", 0, 5000);

        @(posedge clk);
        #1;
        req_valid   = 1'b1;
        req_op      = 3'd1;
        req_account = 17'd1002;
        req_pin     = 17'd1234;
        req_amount  = 19'd1000;
        @(negedge clk);
        chk("midrst_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("midrst");
        req(0, 1002, 1234, 0, 0, 0);
        expect_lit("midrst_bal", 0, 5000);

        req(6, 1000, 1234, 0, 0, 0);
        expect_lit("bad_op", 6, 5000);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
